// File: rtl/aes_rkey_reverse_buffer_if.sv
// Round-key buffer bus: write channel from the forward key expansion and
// read channel towards the inverse-cipher AddRoundKey stage.
interface aes_rkey_reverse_buffer_if #(
    parameter int KEY_W   = 128,
    parameter int ROUND_W = 4
);
    logic               wr_valid;
    logic               wr_ready;
    logic [KEY_W-1:0]   wr_key;
    logic               rd_valid;
    logic               rd_ready;
    logic [KEY_W-1:0]   rd_key;
    logic [ROUND_W-1:0] rd_round;
    logic               rd_last;

    // Buffer side
    modport slave (
        input  wr_valid, wr_key, rd_ready,
        output wr_ready, rd_valid, rd_key, rd_round, rd_last
    );

    // Writer/reader side
    modport master (
        output wr_valid, wr_key, rd_ready,
        input  wr_ready, rd_valid, rd_key, rd_round, rd_last
    );
endinterface

// File: rtl/aes_rkey_reverse_buffer.sv
// AES-128 round-key reverse buffer.
// Collects round keys 0..NUM_KEYS-1 in forward order, then replays them
// from NUM_KEYS-1 down to 0 for the decryption datapath.
// Optional build macro AES_RKEY_REPLAY_EN: after round 0 is consumed the
// sequence restarts at the last round instead of returning to LOAD, so one
// key load serves any number of decrypted blocks.
module aes_rkey_reverse_buffer #(
    parameter int NUM_KEYS = 11,
    parameter int KEY_W    = 128,
    parameter int ROUND_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    aes_rkey_reverse_buffer_if.slave   bus
);
    localparam int CNT_W = $clog2(NUM_KEYS + 1);
    localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(NUM_KEYS);
    localparam logic [CNT_W-1:0]   LAST_WR    = CNT_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0]   ZERO_CNT   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   ONE_CNT    = CNT_W'(1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_KEYS - 1);
    localparam logic [ROUND_W-1:0] ZERO_R     = ROUND_W'(0);
    localparam logic [ROUND_W-1:0] ONE_R      = ROUND_W'(1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   wcnt_r, wcnt_s;
    logic [ROUND_W-1:0] rptr_r, rptr_s;
    logic [KEY_W-1:0]   mem_r [NUM_KEYS];
    logic               wr_hs_s;
    logic [KEY_W-1:0]   sel_key_s;

    // Flush overrides any handshake, so a flushed write never reaches storage
    assign wr_hs_s = bus.wr_valid & (state_r == ST_LOAD) & ~flush;

    // State, write counter and read pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_LOAD;
            wcnt_r  <= ZERO_CNT;
            rptr_r  <= ZERO_R;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
            rptr_r  <= rptr_s;
        end
    end

    // Next-state logic for load/replay sequencing
    always_comb begin
        state_s = state_r;
        wcnt_s  = wcnt_r;
        rptr_s  = rptr_r;
        if (flush) begin
            state_s = ST_LOAD;
            wcnt_s  = ZERO_CNT;
            rptr_s  = ZERO_R;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (bus.wr_valid) begin
                        if (wcnt_r == LAST_WR) begin
                            state_s = ST_READ;
                            wcnt_s  = FULL_CNT;
                            rptr_s  = LAST_ROUND;
                        end else begin
                            wcnt_s  = wcnt_r + ONE_CNT;
                        end
                    end else begin
                        wcnt_s = wcnt_r;
                    end
                end
                ST_READ: begin
                    if (bus.rd_ready) begin
                        if (rptr_r != ZERO_R) begin
                            rptr_s = rptr_r - ONE_R;
                        end else begin
`ifdef AES_RKEY_REPLAY_EN
                            rptr_s  = LAST_ROUND;
`else
                            state_s = ST_LOAD;
                            wcnt_s  = ZERO_CNT;
`endif
                        end
                    end else begin
                        rptr_s = rptr_r;
                    end
                end
                default: begin
                    state_s = ST_LOAD;
                    wcnt_s  = ZERO_CNT;
                    rptr_s  = ZERO_R;
                end
            endcase
        end
    end

    // Key storage: the n-th accepted write lands in slot n
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                mem_r[i] <= {KEY_W{1'b0}};
            end
        end else if (wr_hs_s) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (wcnt_r == CNT_W'(i)) begin
                    mem_r[i] <= bus.wr_key;
                end
            end
        end
    end

    // Select the stored key addressed by the read pointer
    always_comb begin
        sel_key_s = {KEY_W{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (rptr_r == ROUND_W'(i)) begin
                sel_key_s = mem_r[i];
            end else begin
                sel_key_s = sel_key_s;
            end
        end
    end

    // Read outputs are zero whenever no key is being presented
    assign bus.wr_ready = (state_r == ST_LOAD);
    assign bus.rd_valid = (state_r == ST_READ);
    assign bus.rd_key   = bus.rd_valid ? sel_key_s : {KEY_W{1'b0}};
    assign bus.rd_round = bus.rd_valid ? rptr_r : ZERO_R;
    assign bus.rd_last  = bus.rd_valid & (rptr_r == ZERO_R);
endmodule

// File: tb/tb_aes_rkey_reverse_buffer.sv
// Self-checking bench for aes_rkey_reverse_buffer. The reference model keeps
// the written keys in a queue and, once a full set is loaded, builds the
// expected read-out list in reverse order; each read handshake pops it.
// Build with +define+AES_RKEY_REPLAY_EN to exercise the replay variant.
module tb_aes_rkey_reverse_buffer;
    localparam int NK = 11;
    localparam int KW = 128;
    localparam int RW = 4;

    typedef struct {
        logic [KW-1:0] key;
        int            round;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    aes_rkey_reverse_buffer_if #(.KEY_W(KW), .ROUND_W(RW)) bif ();

    aes_rkey_reverse_buffer #(.NUM_KEYS(NK), .KEY_W(KW), .ROUND_W(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bif)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [KW-1:0] wr_list [$];
    logic [KW-1:0] saved   [$];
    item_t         rd_q    [$];
    bit            m_read;

    function automatic logic [KW-1:0] exp_key();
        return m_read ? rd_q[0].key : '0;
    endfunction

    function automatic int exp_round();
        return m_read ? rd_q[0].round : 0;
    endfunction

    function automatic logic [KW-1:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        wr_list.delete();
        saved.delete();
        rd_q.delete();
        m_read = 1'b0;
    endtask

    task automatic fill_rd_q();
        rd_q.delete();
        for (int r = NK - 1; r >= 0; r--) begin
            item_t it;
            it.key   = saved[r];
            it.round = r;
            rd_q.push_back(it);
        end
    endtask

    // drive one cycle, advance the model by the handshake rules, settle #1
    task automatic step(input bit wv, input logic [KW-1:0] wk, input bit rr, input bit fl);
        bif.wr_valid = wv;
        bif.wr_key   = wk;
        bif.rd_ready = rr;
        flush        = fl;
        @(posedge clk);
        if (fl) begin
            wr_list.delete();
            rd_q.delete();
            m_read = 1'b0;
        end else if (!m_read) begin
            if (wv) begin
                wr_list.push_back(wk);
                if (wr_list.size() == NK) begin
                    saved = wr_list;
                    wr_list.delete();
                    fill_rd_q();
                    m_read = 1'b1;
                end
            end
        end else if (rr) begin
            void'(rd_q.pop_front());
            if (rd_q.size() == 0) begin
`ifdef AES_RKEY_REPLAY_EN
                fill_rd_q();
`else
                m_read = 1'b0;
`endif
            end
        end
        #1;
    endtask

    task automatic load_random();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < NK; n++) step(1'b1, rnd_key(), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bif.wr_valid = 1'b0;
        bif.wr_key = '0;
        bif.rd_ready = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bif.wr_ready !== 1'b1 || bif.rd_valid !== 1'b0 || bif.rd_key !== '0 ||
            bif.rd_round !== 4'd0 || bif.rd_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got wr_ready=%b rd_valid=%b rd_round=%0d rd_last=%b key=%h exp 1 0 0 0 zero",
                     bif.wr_ready, bif.rd_valid, bif.rd_round, bif.rd_last, bif.rd_key);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b;
        for (int n = 0; n < NK; n++) begin
            checks++;
            if (bif.wr_ready !== 1'b1 || bif.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_load n=%0d got wr_ready=%b rd_valid=%b exp 1 0", n, bif.wr_ready, bif.rd_valid);
            end
            b = 8'(n + 1);
            step(1'b1, {16{b}}, 1'b1, 1'b0);
        end
        for (int i = 0; i < NK; i++) begin
            b = 8'(NK - i);
            checks++;
            if (bif.rd_valid !== 1'b1 || bif.rd_round !== 4'(NK - 1 - i) || bif.rd_key !== {16{b}} ||
                bif.rd_last !== (i == NK - 1) || bif.wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_read i=%0d got v=%b round=%0d last=%b wr_ready=%b key=%h exp v=1 round=%0d key=%h",
                         i, bif.rd_valid, bif.rd_round, bif.rd_last, bif.wr_ready, bif.rd_key, NK - 1 - i, {16{b}});
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (bif.wr_ready !== !m_read || bif.rd_valid !== m_read) begin
            errors++;
            $display("FAIL basic_after got wr_ready=%b rd_valid=%b exp %b %b", bif.wr_ready, bif.rd_valid, !m_read, m_read);
        end
    endtask

    task automatic test_throttle();
        int pops = 0;
        int want = NK - 1;
        bit rr;
        load_random();
        for (int c = 0; c < 60 && pops < NK; c++) begin
            rr = (c % 4 == 0) || (c % 4 == 3);
            checks++;
            if (bif.rd_valid !== 1'b1 || bif.rd_key !== exp_key() || bif.rd_round !== 4'(exp_round()) ||
                bif.rd_round !== 4'(want) || bif.rd_last !== (want == 0)) begin
                errors++;
                $display("FAIL throttle c=%0d got v=%b round=%0d key=%h exp round=%0d key=%h",
                         c, bif.rd_valid, bif.rd_round, bif.rd_key, want, exp_key());
            end
            if (rr) begin
                pops++;
                want--;
            end
            step(1'b0, '0, rr, 1'b0);
        end
        checks++;
        if (pops != NK) begin
            errors++;
            $display("FAIL throttle_budget got %0d pops exp %0d", pops, NK);
        end
    endtask

    task automatic test_backpressure();
        logic [KW-1:0] ones;
        int pops = 0;
        bit rr;
        ones = '1;
        load_random();
        for (int c = 0; c < 80 && pops < NK; c++) begin
            rr = 1'($urandom_range(0, 1));
            checks++;
            if (bif.wr_ready !== 1'b0 || bif.rd_valid !== 1'b1 || bif.rd_key !== exp_key() ||
                bif.rd_round !== 4'(exp_round())) begin
                errors++;
                $display("FAIL backpressure c=%0d got wr_ready=%b v=%b round=%0d key=%h exp round=%0d key=%h",
                         c, bif.wr_ready, bif.rd_valid, bif.rd_round, bif.rd_key, exp_round(), exp_key());
            end
            if (rr) pops++;
            step(1'b1, ones, rr, 1'b0);
        end
        checks++;
        if (pops != NK) begin
            errors++;
            $display("FAIL backpressure_budget got %0d pops exp %0d", pops, NK);
        end
    endtask

    task automatic test_flush();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) step(1'b1, rnd_key(), 1'b0, 1'b0);
        step(1'b1, rnd_key(), 1'b0, 1'b1);
        for (int n = 0; n < NK; n++) begin
            checks++;
            if (bif.wr_ready !== 1'b1 || bif.rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_write n=%0d got wr_ready=%b rd_valid=%b exp 1 0", n, bif.wr_ready, bif.rd_valid);
            end
            step(1'b1, rnd_key(), 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bif.rd_valid !== 1'b1 || bif.rd_key !== exp_key() || bif.rd_round !== 4'(NK - 1 - i)) begin
                errors++;
                $display("FAIL flush_reload i=%0d got v=%b round=%0d key=%h exp round=%0d key=%h",
                         i, bif.rd_valid, bif.rd_round, bif.rd_key, NK - 1 - i, exp_key());
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (bif.rd_round !== 4'd4) begin
            errors++;
            $display("FAIL flush_at4 got round=%0d exp 4", bif.rd_round);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (bif.rd_valid !== 1'b0 || bif.wr_ready !== 1'b1 || bif.rd_key !== '0 || bif.rd_round !== 4'd0) begin
            errors++;
            $display("FAIL flush_read got v=%b wr_ready=%b round=%0d exp 0 1 0", bif.rd_valid, bif.wr_ready, bif.rd_round);
        end
    endtask

    task automatic test_async_reset();
        load_random();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bif.rd_round !== 4'd7 || bif.rd_key !== exp_key()) begin
            errors++;
            $display("FAIL areset_pre got round=%0d exp 7", bif.rd_round);
        end
        bif.rd_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (bif.rd_valid !== 1'b0 || bif.wr_ready !== 1'b1 || bif.rd_key !== '0 ||
            bif.rd_round !== 4'd0 || bif.rd_last !== 1'b0) begin
            errors++;
            $display("FAIL areset_values got v=%b wr_ready=%b round=%0d last=%b exp 0 1 0 0",
                     bif.rd_valid, bif.wr_ready, bif.rd_round, bif.rd_last);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef AES_RKEY_REPLAY_EN
    task automatic test_replay();
        load_random();
        for (int i = 0; i < 3 * NK; i++) begin
            checks++;
            if (bif.rd_valid !== 1'b1 || bif.wr_ready !== 1'b0 || bif.rd_round !== 4'(NK - 1 - (i % NK)) ||
                bif.rd_key !== exp_key() || bif.rd_last !== ((i % NK) == NK - 1)) begin
                errors++;
                $display("FAIL replay i=%0d got v=%b wr_ready=%b round=%0d key=%h exp round=%0d key=%h",
                         i, bif.rd_valid, bif.wr_ready, bif.rd_round, bif.rd_key, NK - 1 - (i % NK), exp_key());
            end
            step(1'($urandom_range(0, 1)), rnd_key(), 1'b1, 1'b0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_throttle();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef AES_RKEY_REPLAY_EN
        test_replay();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
